// File: rtl/delay_line_pkg.sv
// +----------------------------------------------------------------------------+
// | delay_line_pkg : state encodings shared by the delay-line controller       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package delay_line_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/delay_line_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | delay_line_ctrl_if : RAM port bundle between controller and sample RAM     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface delay_line_ctrl_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 9
);

  logic                     ram_wr;
  logic                     ram_rd;
  logic [ADDRESS_WIDTH-1:0] ram_wr_addr;
  logic [ADDRESS_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]    ram_din;
  logic [DATA_WIDTH-1:0]    ram_dout;

  modport master (
    output ram_wr, ram_rd, ram_wr_addr, ram_rd_addr, ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_wr, ram_rd, ram_wr_addr, ram_rd_addr, ram_din,
    output ram_dout
  );

endinterface

`default_nettype wire

// File: rtl/delay_line_ctrl.sv
// +----------------------------------------------------------------------------+
// | delay_line_ctrl : programmable sample delay line driving an external RAM   |
// | Optional fill muting enabled by defining DELAY_LINE_CTRL_MUTE_EN           |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 9
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     en,
  input  wire logic [DATA_WIDTH-1:0]    sample_in,
  input  wire logic [ADDRESS_WIDTH-1:0] delay,
  input  wire logic                     delay_ld,
  delay_line_ctrl_if.master             ram,
  output logic      [DATA_WIDTH-1:0]    sample_out,
  output logic                          out_valid,
  output logic      [1:0]               state
);

  localparam logic [ADDRESS_WIDTH-1:0] c_PTR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
  logic [ADDRESS_WIDTH-1:0] r_delay_q;
  logic                     r_v1;
  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] w_delay_sel;

  // A delay loaded together with a sample already governs that sample's read.
  assign w_delay_sel     = delay_ld ? delay : r_delay_q;

  assign ram.ram_wr      = en;
  assign ram.ram_rd      = en;
  assign ram.ram_wr_addr = en ? r_wr_ptr : '0;
  assign ram.ram_din     = en ? sample_in : '0;
  assign ram.ram_rd_addr = en ? (r_wr_ptr - w_delay_sel) : '0;

  assign state = r_state;

`ifdef DELAY_LINE_CTRL_MUTE_EN
  localparam logic [ADDRESS_WIDTH:0] c_DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] c_ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  logic [ADDRESS_WIDTH:0] r_fill_cnt;
  logic                   r_mute1;
  logic [ADDRESS_WIDTH:0] w_d;
  logic [ADDRESS_WIDTH:0] w_fill_base;
  logic [ADDRESS_WIDTH:0] w_fill_nxt;
  logic                   w_mute;

  assign w_d         = (w_delay_sel == '0) ? c_DEPTH : {1'b0, w_delay_sel};
  assign w_fill_base = delay_ld ? '0 : r_fill_cnt;
  // Fewer than D samples in this epoch means the read location holds stale data.
  assign w_mute      = (w_fill_base < w_d);
  assign w_fill_nxt  = w_mute ? (w_fill_base + c_ONE) : w_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_delay_q  <= '0;
      r_v1       <= 1'b0;
      out_valid  <= 1'b0;
      sample_out <= '0;
      r_state    <= ST_IDLE;
`ifdef DELAY_LINE_CTRL_MUTE_EN
      r_fill_cnt <= '0;
      r_mute1    <= 1'b0;
`endif
    end else begin
      if (delay_ld) begin
        r_delay_q <= delay;
      end
      if (en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      r_v1      <= en;
      out_valid <= r_v1;
`ifdef DELAY_LINE_CTRL_MUTE_EN
      r_mute1 <= w_mute;
      if (r_v1) begin
        sample_out <= r_mute1 ? '0 : ram.ram_dout;
      end
      if (en) begin
        r_fill_cnt <= w_fill_nxt;
        r_state    <= (w_fill_nxt == w_d) ? ST_RUN : ST_FILL;
      end else if (delay_ld) begin
        r_fill_cnt <= '0;
        if (r_state != ST_IDLE) begin
          r_state <= ST_FILL;
        end
      end
`else
      if (r_v1) begin
        sample_out <= ram.ram_dout;
      end
      if (en) begin
        r_state <= ST_RUN;
      end
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_delay_line_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_delay_line_ctrl : directed self-checking bench with a behavioural RAM   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_delay_line_ctrl;

  localparam int AW = 9;
  localparam int DW = 9;
  localparam logic [DW-1:0] c_STALE = 9'h155;
`ifdef DELAY_LINE_CTRL_MUTE_EN
  localparam logic [1:0] c_ST_FIRST = 2'd1;
`else
  localparam logic [1:0] c_ST_FIRST = 2'd2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          delay_ld = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic [AW-1:0] delay = '0;
  logic [DW-1:0] sample_out;
  logic          out_valid;
  logic [1:0]    state;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int got_v[$];
  int got_c[$];

  delay_line_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) ram_if ();

  delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sample_in  (sample_in),
    .delay      (delay),
    .delay_ld   (delay_ld),
    .ram        (ram_if),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Registered-read RAM, read-before-write; never-written cells return a stale pattern.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            wrote [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_if.ram_rd) ram_if.ram_dout <= wrote[ram_if.ram_rd_addr] ? mem[ram_if.ram_rd_addr] : c_STALE;
    if (ram_if.ram_wr) begin
      mem[ram_if.ram_wr_addr]   <= ram_if.ram_din;
      wrote[ram_if.ram_wr_addr] <= 1'b1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_v.push_back(int'(sample_out));
      got_c.push_back(cyc);
    end
  end

  task automatic drive(input logic e, input logic [DW-1:0] s, input logic ld, input logic [AW-1:0] d);
    @(negedge clk);
    en = e; sample_in = s; delay_ld = ld; delay = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; delay_ld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got_v.delete(); got_c.delete();
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    vectors++; if (sample_out !== '0) begin errors++; $display("FAIL reset_sample got=%0d exp=0", sample_out); end
    vectors++; if (ram_if.ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got=%b exp=0", ram_if.ram_wr); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_delay3();
    int c4 = 0;
    do_reset();
    drive(1'b0, '0, 1'b1, 9'd3);
    drive(1'b0, '0, 1'b0, '0);
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL ld_idle_state got=%0d exp=0", state); end
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, DW'(k), 1'b0, '0);
      if (k == 4) c4 = cyc;
      #1;
      if (k == 1) begin
        vectors++; if (ram_if.ram_wr !== 1'b1 || ram_if.ram_rd !== 1'b1) begin errors++; $display("FAIL d3_strobe got=%b%b exp=11", ram_if.ram_wr, ram_if.ram_rd); end
        vectors++; if (ram_if.ram_rd_addr !== 9'd509) begin errors++; $display("FAIL d3_rd_addr got=%0d exp=509", ram_if.ram_rd_addr); end
        vectors++; if (ram_if.ram_din !== 9'd1) begin errors++; $display("FAIL d3_din got=%0d exp=1", ram_if.ram_din); end
      end
      if (k == 2) begin
        vectors++; if (state !== c_ST_FIRST) begin errors++; $display("FAIL d3_state_first got=%0d exp=%0d", state, c_ST_FIRST); end
      end
      if (k == 4) begin
        vectors++; if (state !== 2'd2) begin errors++; $display("FAIL d3_state_run got=%0d exp=2", state); end
      end
    end
    idle(3);
    vectors++; if (got_v.size() != 12) begin errors++; $display("FAIL d3_count got=%0d exp=12", got_v.size()); end
    for (int k = 1; k <= 12 && k <= got_v.size(); k++) begin
`ifdef DELAY_LINE_CTRL_MUTE_EN
      if (k <= 3) begin
        vectors++; if (got_v[k-1] != 0) begin errors++; $display("FAIL d3_mute k=%0d got=%0d exp=0", k, got_v[k-1]); end
      end
`endif
      if (k > 3) begin
        vectors++; if (got_v[k-1] != k - 3) begin errors++; $display("FAIL d3_out k=%0d got=%0d exp=%0d", k, got_v[k-1], k - 3); end
      end
    end
    if (got_v.size() >= 4) begin
      vectors++; if (got_c[3] != c4 + 2) begin errors++; $display("FAIL d3_latency got=%0d exp=%0d", got_c[3], c4 + 2); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 600; k++) begin
      drive(1'b1, DW'(k & 511), (k == 1), 9'd5);
      #1;
      if (k == 1) begin
        vectors++; if (ram_if.ram_rd_addr !== 9'd507) begin errors++; $display("FAIL wrap_ld_rd_addr got=%0d exp=507", ram_if.ram_rd_addr); end
      end
      if (k == 512) begin
        vectors++; if (ram_if.ram_wr_addr !== 9'd511) begin errors++; $display("FAIL wrap_wr_max got=%0d exp=511", ram_if.ram_wr_addr); end
      end
      if (k == 513) begin
        vectors++; if (ram_if.ram_wr_addr !== 9'd0) begin errors++; $display("FAIL wrap_wr_zero got=%0d exp=0", ram_if.ram_wr_addr); end
        vectors++; if (ram_if.ram_rd_addr !== 9'd507) begin errors++; $display("FAIL wrap_rd_addr got=%0d exp=507", ram_if.ram_rd_addr); end
      end
    end
    idle(3);
    vectors++; if (got_v.size() != 600) begin errors++; $display("FAIL wrap_count got=%0d exp=600", got_v.size()); end
    for (int k = 1; k <= 600 && k <= got_v.size(); k++) begin
`ifdef DELAY_LINE_CTRL_MUTE_EN
      if (k <= 5) begin
        vectors++; if (got_v[k-1] != 0) begin errors++; $display("FAIL wrap_mute k=%0d got=%0d exp=0", k, got_v[k-1]); end
      end
`endif
      if (k > 5) begin
        vectors++; if (got_v[k-1] != ((k - 5) & 511)) begin errors++; $display("FAIL wrap_out k=%0d got=%0d exp=%0d", k, got_v[k-1], (k - 5) & 511); end
      end
    end
  endtask

  task automatic test_delay0();
    do_reset();
    drive(1'b0, '0, 1'b1, 9'd0);
    for (int k = 1; k <= 520; k++) drive(1'b1, DW'(k & 511), 1'b0, '0);
    idle(3);
    vectors++; if (got_v.size() != 520) begin errors++; $display("FAIL d0_count got=%0d exp=520", got_v.size()); end
    for (int k = 1; k <= 520 && k <= got_v.size(); k++) begin
`ifdef DELAY_LINE_CTRL_MUTE_EN
      if (k <= 512) begin
        vectors++; if (got_v[k-1] != 0) begin errors++; $display("FAIL d0_mute k=%0d got=%0d exp=0", k, got_v[k-1]); end
      end
`endif
      if (k > 512) begin
        vectors++; if (got_v[k-1] != k - 512) begin errors++; $display("FAIL d0_out k=%0d got=%0d exp=%0d", k, got_v[k-1], k - 512); end
      end
    end
  endtask

  task automatic test_reload();
    int exp;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, DW'(k), (k == 1) || (k == 11), (k == 11) ? 9'd10 : 9'd3);
      #1;
      if (k == 11) begin
        vectors++; if (state !== 2'd2) begin errors++; $display("FAIL rl_state_before got=%0d exp=2", state); end
        vectors++; if (ram_if.ram_rd_addr !== 9'd0) begin errors++; $display("FAIL rl_rd_addr got=%0d exp=0", ram_if.ram_rd_addr); end
      end
      if (k == 12) begin
        vectors++; if (state !== c_ST_FIRST) begin errors++; $display("FAIL rl_state_fill got=%0d exp=%0d", state, c_ST_FIRST); end
      end
      if (k == 21) begin
        vectors++; if (state !== 2'd2) begin errors++; $display("FAIL rl_state_run got=%0d exp=2", state); end
      end
    end
    idle(3);
    vectors++; if (got_v.size() != 40) begin errors++; $display("FAIL rl_count got=%0d exp=40", got_v.size()); end
    for (int k = 1; k <= 40 && k <= got_v.size(); k++) begin
      exp = (k <= 3) ? 0 : (k <= 10) ? k - 3 : (k <= 20) ? 0 : k - 10;
`ifdef DELAY_LINE_CTRL_MUTE_EN
      vectors++; if (got_v[k-1] != exp) begin errors++; $display("FAIL rl_out k=%0d got=%0d exp=%0d", k, got_v[k-1], exp); end
`else
      if (exp != 0) begin
        vectors++; if (got_v[k-1] != exp) begin errors++; $display("FAIL rl_out k=%0d got=%0d exp=%0d", k, got_v[k-1], exp); end
      end
`endif
    end
  endtask

  task automatic test_gap();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, DW'(k), (k == 1), 9'd3);
      #1;
      vectors++; if (ram_if.ram_rd_addr !== AW'((k - 4) & 511)) begin errors++; $display("FAIL gap_rd_addr k=%0d got=%0d exp=%0d", k, ram_if.ram_rd_addr, (k - 4) & 511); end
      if (k >= 5) begin
        vectors++; if (out_valid !== 1'b0 || sample_out !== DW'(k - 4)) begin errors++; $display("FAIL gap_hold k=%0d got=%b/%0d exp=0/%0d", k, out_valid, sample_out, k - 4); end
      end
      for (int g = 0; g < 2; g++) begin
        drive(1'b0, DW'(k), 1'b0, 9'd3);
        #1;
        vectors++;
        if (ram_if.ram_wr !== 1'b0 || ram_if.ram_rd !== 1'b0 || ram_if.ram_wr_addr !== '0 || ram_if.ram_din !== '0) begin
          errors++; $display("FAIL gap_idle k=%0d got=wr%b rd%b wa%0d din%0d exp=all 0", k, ram_if.ram_wr, ram_if.ram_rd, ram_if.ram_wr_addr, ram_if.ram_din);
        end
      end
    end
    idle(3);
    vectors++; if (got_v.size() != 10) begin errors++; $display("FAIL gap_count got=%0d exp=10", got_v.size()); end
    for (int k = 4; k <= 10 && k <= got_v.size(); k++) begin
      vectors++; if (got_v[k-1] != k - 3) begin errors++; $display("FAIL gap_out k=%0d got=%0d exp=%0d", k, got_v[k-1], k - 3); end
    end
  endtask

  task automatic test_reset_mid();
    int n_at_rst;
    do_reset();
    for (int k = 1; k <= 8; k++) drive(1'b1, DW'(k), (k == 1), 9'd3);
    @(negedge clk);
    en = 1'b0; rst_n = 1'b0;
    #1;
    n_at_rst = got_v.size();
    vectors++; if (state !== 2'd0) begin errors++; $display("FAIL mid_state got=%0d exp=0", state); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    vectors++; if (sample_out !== '0) begin errors++; $display("FAIL mid_sample got=%0d exp=0", sample_out); end
    @(negedge clk); rst_n = 1'b1;
    idle(4);
    vectors++; if (got_v.size() != n_at_rst) begin errors++; $display("FAIL mid_stray got=%0d exp=%0d", got_v.size(), n_at_rst); end
    drive(1'b1, 9'd77, 1'b0, '0);
    #1;
    vectors++; if (ram_if.ram_wr_addr !== 9'd0) begin errors++; $display("FAIL mid_wr_addr got=%0d exp=0", ram_if.ram_wr_addr); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_delay3();
    test_wrap();
    test_delay0();
    test_reload();
    test_gap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/delay_line_ctrl.md
DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 9, the RAM address width; depth is 2^ADDRESS_WIDTH.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 9, the sample width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port en  input  1  sample strobe; one sample per high cycle.
REQ-006 The block SHALL have port sample_in  input  DATA_WIDTH  sample to store.
REQ-007 The block SHALL have port delay  input  ADDRESS_WIDTH  requested delay in samples; 0 means 2^ADDRESS_WIDTH.
REQ-008 The block SHALL have port delay_ld  input  1  pulse that latches delay.
REQ-009 The block SHALL have port ram_wr  output  1  RAM write enable.
REQ-010 The block SHALL have port ram_rd  output  1  RAM read enable.
REQ-011 The block SHALL have ports ram_wr_addr and ram_rd_addr  output  ADDRESS_WIDTH  RAM addresses.
REQ-012 The block SHALL have port ram_din  output  DATA_WIDTH  RAM write data.
REQ-013 The block SHALL have port ram_dout  input  DATA_WIDTH  RAM read data, registered, valid one cycle after ram_rd.
REQ-014 The block SHALL have ports sample_out  output  DATA_WIDTH  and out_valid  output  1, the delayed sample and its qualifier.
REQ-015 The block SHALL have port state  output  2  current FSM state.

Function
REQ-016 Effective delay D SHALL be delay_q when delay_q is nonzero, else 2^ADDRESS_WIDTH; D SHALL be held in ADDRESS_WIDTH+1 bits.
REQ-017 In an en cycle, ram_wr and ram_rd SHALL be 1 combinationally, with ram_wr_addr=wr_ptr, ram_din=sample_in and ram_rd_addr=(wr_ptr-delay_q) mod 2^ADDRESS_WIDTH; all four RAM controls SHALL be 0 when en is 0.
REQ-018 wr_ptr SHALL increment modulo 2^ADDRESS_WIDTH on every en, wrapping from max to 0.
REQ-019 For en in cycle N, out_valid SHALL pulse in cycle N+2 with sample_out registered from ram_dout; sample_out SHALL hold between pulses.
REQ-020 The FSM SHALL have states IDLE=0, FILL=1 and RUN=2.
REQ-021 IDLE SHALL go to FILL on the first en.
REQ-022 fill_cnt (ADDRESS_WIDTH+1 bits) SHALL count en cycles in the current epoch and saturate at D.
REQ-023 FILL SHALL go to RUN on the en at which fill_cnt reaches D.
REQ-024 A sample read while fill_cnt<D SHALL be muted, i.e. sample_out=0 with out_valid still pulsing.
REQ-025 delay_ld SHALL latch delay into delay_q, clear fill_cnt, and enter FILL, or stay in IDLE if no sample has been seen since reset.
REQ-026 When delay_ld and en occur together, the new delay SHALL apply to that same sample, which counts as the first of the new epoch.
REQ-027 The two-stage output pipeline SHALL continue draining across delay_ld, with each sample's mute decided at read time.

Reset
REQ-028 Asserting rst_n low SHALL asynchronously clear wr_ptr, fill_cnt, delay_q, sample_out, out_valid, the pipeline valids, and state to IDLE.
REQ-029 Reset mid-operation SHALL discard in-flight samples, so that no out_valid follows reset release without a new en.
REQ-030 RAM contents SHALL not be cleared by reset; muting alone SHALL hide stale data.

Configuration
REQ-031 With DELAY_LINE_CTRL_MUTE_EN defined, REQ-021 to REQ-025 SHALL apply in full.
REQ-032 Without DELAY_LINE_CTRL_MUTE_EN, fill_cnt SHALL be omitted, state SHALL go to RUN on the first en, delay_ld SHALL only latch delay_q, and sample_out SHALL be raw ram_dout.

Structure
REQ-033 Package delay_line_pkg SHALL hold the state enum type and the state encodings.
REQ-034 There SHALL be no sub-module; the RAM is instantiated beside this block by the integrating top.

Verification (ADDRESS_WIDTH=9, DATA_WIDTH=9)
REQ-035 delay_ld with delay=3, then en every cycle with samples 1,2,3,... -> out_valid outputs 0,0,0,1,2,3,..., with first nonzero value 1 two cycles after en of sample 4.
REQ-036 delay=5, 600 consecutive samples -> the en after wr_ptr=511 gives wr_ptr=0 and ram_rd_addr=507, and output stays sample k-5 across the wrap.
REQ-037 delay=0 -> the first 512 outputs are 0, and output 513 equals sample 1.
REQ-038 In RUN at delay 3, delay_ld with delay=10 together with en -> 10 muted outputs, then samples continue at a lag of 10.
REQ-039 en every 3rd cycle -> ram_wr and ram_rd are 0 in the gap cycles and values are the same as in the contiguous case.
REQ-040 rst_n low for 1 cycle in RUN -> state=0, out_valid=0, sample_out=0, no stray out_valid, and ram_wr_addr=0 on the next en.
